// File: rtl/alarm_ctrl_pkg.sv
// Shared clock definitions: controller state encodings and BCD wrap limits
// for the alarm hour/minute registers.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETH   = 3'd1,
    SETM   = 3'd2,
    RING   = 3'd3,
    SNOOZE = 3'd4
  } state_e;

  localparam logic [5:0] HOUR_MAX = 6'h23;
  localparam logic [6:0] MIN_MAX  = 7'h59;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Button pulses, time inputs and display/buzzer outputs of the alarm controller.
// The master drives the inputs; the controller attaches through the slave modport.
interface alarm_ctrl_if;

  logic       EN1HZ;
  logic       SIG2HZ;
  logic       ALSET;
  logic       SELECT;
  logic       ADJUST;
  logic       STOP;
  logic       ARM;
  logic [5:0] CUR_HOUR;
  logic [6:0] CUR_MIN;
  logic [6:0] CUR_SEC;
  logic [5:0] AL_HOUR;
  logic [6:0] AL_MIN;
  logic       ALDISP;
  logic       HOURON;
  logic       MINON;
  logic       BUZZ;
  logic       RINGING;

  modport master (
    output EN1HZ, SIG2HZ, ALSET, SELECT, ADJUST, STOP, ARM,
           CUR_HOUR, CUR_MIN, CUR_SEC,
    input  AL_HOUR, AL_MIN, ALDISP, HOURON, MINON, BUZZ, RINGING
  );

  modport slave (
    input  EN1HZ, SIG2HZ, ALSET, SELECT, ADJUST, STOP, ARM,
           CUR_HOUR, CUR_MIN, CUR_SEC,
    output AL_HOUR, AL_MIN, ALDISP, HOURON, MINON, BUZZ, RINGING
  );

endinterface

// File: rtl/alarm_ctrl_bcd_inc.sv
// Two-digit BCD increment that wraps to zero after MAX. The ones digit is
// always 4 bits; the tens digit takes the remaining W-4 bits.
module bcd_inc #(
  parameter int           W   = 7,
  parameter logic [W-1:0] MAX = '0
) (
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  logic [W-5:0] tens_inc;
  logic [3:0]   ones_inc;

  assign tens_inc = val_i[W-1:4] + (W-4)'(1);
  assign ones_inc = val_i[3:0] + 4'd1;

  always_comb begin
    if (val_i == MAX) begin
      val_o = '0;
    end else if (val_i[3:0] == 4'd9) begin
      val_o = {tens_inc, 4'd0};
    end else begin
      val_o = {val_i[W-1:4], ones_inc};
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: alarm-time setting from the push buttons, match against
// the running time, and ring / snooze / timeout sequencing of the buzzer.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input logic         CLK,
  input logic         RST,
  alarm_ctrl_if.slave bus
);

  localparam int CW = $clog2(((RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC) + 1);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SEC - 1);

  state_e        state_q, state_d;
  logic [5:0]    al_hour_q, al_hour_d, hour_inc;
  logic [6:0]    al_min_q, al_min_d, min_inc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en1hz_dly_q;
  logic          match;

  bcd_inc #(.W(6), .MAX(HOUR_MAX)) u_hour_inc (.val_i(al_hour_q), .val_o(hour_inc));
  bcd_inc #(.W(7), .MAX(MIN_MAX))  u_min_inc  (.val_i(al_min_q),  .val_o(min_inc));

  // Time counters advance on EN1HZ, so compare one cycle later when they have settled.
  assign match = en1hz_dly_q & bus.ARM
               & (bus.CUR_HOUR == al_hour_q)
               & (bus.CUR_MIN  == al_min_q)
               & (bus.CUR_SEC  == 7'h00);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      al_hour_q   <= 6'h07;
      al_min_q    <= 7'h00;
      cnt_q       <= '0;
      en1hz_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      al_hour_q   <= al_hour_d;
      al_min_q    <= al_min_d;
      cnt_q       <= cnt_d;
      en1hz_dly_q <= bus.EN1HZ;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.ALSET) begin
          state_d = SETH;
        end else if (match) begin
          state_d = RING;
          cnt_d   = '0;
        end
      end

      SETH: begin
        if (bus.ADJUST) al_hour_d = hour_inc;
        if (bus.ALSET)       state_d = IDLE;
        else if (bus.SELECT) state_d = SETM;
      end

      SETM: begin
        if (bus.ADJUST) al_min_d = min_inc;
        if (bus.ALSET)       state_d = IDLE;
        else if (bus.SELECT) state_d = SETH;
      end

      RING: begin
        if (bus.STOP || !bus.ARM) begin
          state_d = IDLE;
        end else if (bus.SELECT) begin
          state_d = SNOOZE;
          cnt_d   = '0;
        end else if (bus.EN1HZ) begin
          if (cnt_q == RING_LAST) state_d = IDLE;
          else                    cnt_d   = cnt_q + CW'(1);
        end
      end

      SNOOZE: begin
        if (bus.STOP || !bus.ARM) begin
          state_d = IDLE;
        end else if (bus.EN1HZ) begin
          if (cnt_q == SNOOZE_LAST) begin
            state_d = RING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.AL_HOUR = al_hour_q;
  assign bus.AL_MIN  = al_min_q;
  assign bus.ALDISP  = (state_q == SETH) | (state_q == SETM);
  assign bus.HOURON  = ~((state_q == SETH) & bus.SIG2HZ);
  assign bus.MINON   = ~((state_q == SETM) & bus.SIG2HZ);
  assign bus.BUZZ    = (state_q == RING) & bus.SIG2HZ;
  assign bus.RINGING = (state_q == RING) | (state_q == SNOOZE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: setting sequence, BCD wraps, ring timeout,
// snooze cycle, ARM gating and reset mid-snooze.
module tb_alarm_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alarm_ctrl_if bus ();

  alarm_ctrl #(.RING_SEC(60), .SNOOZE_SEC(300)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then drop all one-cycle pulses.
  task automatic step();
    @(posedge clk);
    #1;
    bus.EN1HZ  = 1'b0;
    bus.ALSET  = 1'b0;
    bus.SELECT = 1'b0;
    bus.ADJUST = 1'b0;
    bus.STOP   = 1'b0;
  endtask

  task automatic sec_pulse();
    bus.EN1HZ = 1'b1;
    step();
    step();
  endtask

  task automatic adjust_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ADJUST = 1'b1;
      step();
    end
  endtask

  // Time rolls from hr_prev:59:59 to hr:00:00 on an EN1HZ; RING follows two edges later.
  task automatic trigger_match(input logic [5:0] hr_prev, input logic [5:0] hr);
    bus.CUR_HOUR = hr_prev;
    bus.CUR_MIN  = 7'h59;
    bus.CUR_SEC  = 7'h59;
    bus.EN1HZ    = 1'b1;
    step();
    bus.CUR_HOUR = hr;
    bus.CUR_MIN  = 7'h00;
    bus.CUR_SEC  = 7'h00;
    check("match_pending_not_ringing", bus.RINGING, 1'b0);
    step();
    bus.CUR_SEC  = 7'h01;
  endtask

  initial begin
    bus.EN1HZ    = 1'b0;
    bus.SIG2HZ   = 1'b0;
    bus.ALSET    = 1'b0;
    bus.SELECT   = 1'b0;
    bus.ADJUST   = 1'b0;
    bus.STOP     = 1'b0;
    bus.ARM      = 1'b0;
    bus.CUR_HOUR = 6'h12;
    bus.CUR_MIN  = 7'h34;
    bus.CUR_SEC  = 7'h56;
    rst          = 1'b1;
    step();
    step();
    rst = 1'b0;

    check("rst_al_hour", bus.AL_HOUR, 6'h07);
    check("rst_al_min",  bus.AL_MIN,  7'h00);
    check("rst_aldisp",  bus.ALDISP,  1'b0);
    check("rst_houron",  bus.HOURON,  1'b1);
    check("rst_minon",   bus.MINON,   1'b1);
    check("rst_buzz",    bus.BUZZ,    1'b0);
    check("rst_ringing", bus.RINGING, 1'b0);

    // Setting sequence: ALSET, 3xADJUST, SELECT, 2xADJUST, ALSET
    bus.ALSET = 1'b1;
    step();
    check("seth_aldisp", bus.ALDISP, 1'b1);
    bus.SIG2HZ = 1'b1; #1;
    check("seth_houron_blink", bus.HOURON, 1'b0);
    check("seth_minon_steady", bus.MINON,  1'b1);
    bus.SIG2HZ = 1'b0; #1;
    check("seth_houron_lit", bus.HOURON, 1'b1);
    adjust_n(3);
    check("hour_07_to_10", bus.AL_HOUR, 6'h10);
    bus.SELECT = 1'b1;
    step();
    bus.SIG2HZ = 1'b1; #1;
    check("setm_minon_blink",   bus.MINON,  1'b0);
    check("setm_houron_steady", bus.HOURON, 1'b1);
    check("setm_aldisp",        bus.ALDISP, 1'b1);
    bus.SIG2HZ = 1'b0; #1;
    adjust_n(2);
    check("min_00_to_02", bus.AL_MIN, 7'h02);
    bus.ALSET = 1'b1;
    step();
    check("idle_aldisp", bus.ALDISP, 1'b0);
    bus.SIG2HZ = 1'b1; #1;
    check("idle_houron", bus.HOURON, 1'b1);
    check("idle_minon",  bus.MINON,  1'b1);
    bus.SIG2HZ = 1'b0; #1;
    check("set_al_hour", bus.AL_HOUR, 6'h10);
    check("set_al_min",  bus.AL_MIN,  7'h02);

    // Wrap tests, then restore alarm to 07:00 using SELECT+ADJUST together
    bus.ALSET = 1'b1;
    step();
    adjust_n(13);
    check("hour_to_23", bus.AL_HOUR, 6'h23);
    adjust_n(1);
    check("hour_wrap_00", bus.AL_HOUR, 6'h00);
    bus.SELECT = 1'b1;
    step();
    adjust_n(7);
    check("min_to_09", bus.AL_MIN, 7'h09);
    adjust_n(1);
    check("min_09_to_10", bus.AL_MIN, 7'h10);
    adjust_n(49);
    check("min_to_59", bus.AL_MIN, 7'h59);
    adjust_n(1);
    check("min_wrap_00", bus.AL_MIN, 7'h00);
    bus.SELECT = 1'b1;
    step();
    adjust_n(6);
    bus.SELECT = 1'b1;
    bus.ADJUST = 1'b1;
    step();
    check("sel_adj_hour", bus.AL_HOUR, 6'h07);
    check("sel_adj_min",  bus.AL_MIN,  7'h00);
    bus.SIG2HZ = 1'b1; #1;
    check("sel_adj_now_setm", bus.MINON, 1'b0);
    bus.SIG2HZ = 1'b0; #1;
    bus.ALSET = 1'b1;
    step();

    // Ring and automatic timeout after 60 EN1HZ
    bus.ARM = 1'b1;
    trigger_match(6'h06, 6'h07);
    check("ring_entered", bus.RINGING, 1'b1);
    bus.SIG2HZ = 1'b1; #1;
    check("ring_buzz_hi", bus.BUZZ, 1'b1);
    bus.SIG2HZ = 1'b0; #1;
    check("ring_buzz_lo", bus.BUZZ, 1'b0);
    for (int i = 0; i < 59; i++) sec_pulse();
    check("ring_after_59", bus.RINGING, 1'b1);
    sec_pulse();
    check("ring_timeout_60", bus.RINGING, 1'b0);

    // Snooze for 300 EN1HZ, back to RING, then STOP
    trigger_match(6'h06, 6'h07);
    bus.ALSET = 1'b1;
    step();
    check("ring_ignores_alset", bus.ALDISP, 1'b0);
    bus.SELECT = 1'b1;
    step();
    bus.SIG2HZ = 1'b1; #1;
    check("snooze_ringing", bus.RINGING, 1'b1);
    check("snooze_buzz",    bus.BUZZ,    1'b0);
    for (int i = 0; i < 299; i++) sec_pulse();
    check("snooze_after_299", bus.BUZZ, 1'b0);
    sec_pulse();
    check("snooze_back_to_ring", bus.BUZZ, 1'b1);
    bus.SIG2HZ = 1'b0;
    bus.STOP   = 1'b1;
    step();
    check("stop_idle", bus.RINGING, 1'b0);

    // ARM gating
    bus.ARM = 1'b0;
    trigger_match(6'h06, 6'h07);
    step();
    check("disarmed_no_ring", bus.RINGING, 1'b0);
    bus.ARM = 1'b1;
    trigger_match(6'h06, 6'h07);
    bus.SELECT = 1'b1;
    step();
    check("snooze_before_disarm", bus.RINGING, 1'b1);
    bus.ARM = 1'b0;
    step();
    check("disarm_in_snooze", bus.RINGING, 1'b0);
    bus.ARM = 1'b1;

    // Reset during snooze with a non-default alarm time
    bus.ALSET = 1'b1;
    step();
    adjust_n(1);
    bus.ALSET = 1'b1;
    step();
    check("alarm_08", bus.AL_HOUR, 6'h08);
    trigger_match(6'h07, 6'h08);
    bus.SELECT = 1'b1;
    step();
    check("snooze_before_rst", bus.RINGING, 1'b1);
    bus.SIG2HZ = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_snooze_ringing", bus.RINGING, 1'b0);
    check("rst_snooze_buzz",    bus.BUZZ,    1'b0);
    check("rst_snooze_hour",    bus.AL_HOUR, 6'h07);
    check("rst_snooze_min",     bus.AL_MIN,  7'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller for the digital clock. Holds the alarm time (BCD hours and minutes) and sequences alarm-time setting from the push buttons. Compares the alarm time against the running time counters and drives the buzzer through ring, snooze and timeout phases. Sits beside the time-adjust state machine and shares the debounced SELECT/ADJUST pulses, the 1 Hz enable and the 2 Hz blink signal.

## Interface
- RING_SEC, 60: ring duration in seconds before automatic stop.
- SNOOZE_SEC, 300: snooze interval in seconds before ringing resumes.
- CW, derived: counter width, $clog2(max(RING_SEC,SNOOZE_SEC)+1).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- EN1HZ  in  1  one-CLK pulse per second, from the prescaler; the time counters advance on it.
- SIG2HZ  in  1  2 Hz square wave for blink and beep.
- ALSET  in  1  one-CLK pulse; enter or leave alarm-set mode.
- SELECT  in  1  one-CLK pulse; switch the set digit, or snooze while ringing.
- ADJUST  in  1  one-CLK pulse; increment the selected alarm digit.
- STOP  in  1  one-CLK pulse; silence the alarm.
- ARM  in  1  level; alarm enabled.
- CUR_HOUR  in  6  BCD current hour, {tens[1:0],ones[3:0]}.
- CUR_MIN  in  7  BCD current minute, {tens[2:0],ones[3:0]}.
- CUR_SEC  in  7  BCD current second.
- AL_HOUR  out  6  BCD alarm hour; reset 6'h07.
- AL_MIN  out  7  BCD alarm minute; reset 7'h00.
- ALDISP  out  1  display mux selects the alarm time; reset 0.
- HOURON, MINON  out  1  each  active-low blink gates for the hour and minute digits; reset 1.
- BUZZ  out  1  buzzer drive; reset 0.
- RINGING  out  1  high in RING or SNOOZE; reset 0.

## Operation
- States: IDLE, SETH, SETM, RING, SNOOZE. Reset state is IDLE.
- Match: asserted on the cycle after EN1HZ (registered copy EN1HZ_d). Condition is ARM & CUR_HOUR==AL_HOUR & CUR_MIN==AL_MIN & CUR_SEC==7'h00.
- IDLE:
  - ALSET goes to SETH.
  - Otherwise, match goes to RING and clears the counter.
  - ALSET has priority over match; a match lost this way is not retried.
- SETH:
  - ADJUST increments AL_HOUR in BCD from 00 to 23; 23 wraps to 00.
  - SELECT goes to SETM. ALSET goes to IDLE.
- SETM:
  - ADJUST increments AL_MIN in BCD from 00 to 59; 59 wraps to 00.
  - SELECT goes to SETH. ALSET goes to IDLE.
- In SETH/SETM, when SELECT and ADJUST arrive in the same cycle, the increment applies to the digit of the current state, then the state changes.
- RING:
  - The counter increments on each EN1HZ.
  - Exit priority: STOP or ~ARM goes to IDLE; then SELECT goes to SNOOZE and clears the counter; then counter==RING_SEC-1 together with EN1HZ goes to IDLE.
- SNOOZE:
  - The counter increments on each EN1HZ.
  - STOP or ~ARM goes to IDLE.
  - counter==SNOOZE_SEC-1 together with EN1HZ goes to RING and clears the counter.
- ALSET, and ADJUST, are ignored in RING and SNOOZE. Match is ignored outside IDLE.
- Outputs are combinational from state:
  - ALDISP = SETH | SETM.
  - HOURON = ~(SETH & SIG2HZ).
  - MINON = ~(SETM & SIG2HZ).
  - BUZZ = RING & SIG2HZ.
  - RINGING = RING | SNOOZE.
- Invalid BCD on the AL registers cannot occur. The increment only produces legal codes, and reset loads legal values.

## Timing
- State, alarm registers, counter and EN1HZ_d update on posedge CLK.
- Button pulse to state or register change: 1 cycle.
- EN1HZ at which the time counters reach the match time: EN1HZ_d is high 1 cycle later, RING is entered 2 cycles later, and BUZZ follows SIG2HZ from then on.
- Ring duration: exactly RING_SEC EN1HZ pulses after entry.
- Snooze: exactly SNOOZE_SEC EN1HZ pulses after entry.
- RST mid-operation returns to the reset values on the next edge. Any ring or snooze is cancelled, and the alarm time returns to 07:00.

## Structure
- Shared package clock_pkg holds:
  - the state encodings: IDLE=3'd0, SETH=3'd1, SETM=3'd2, RING=3'd3, SNOOZE=3'd4;
  - the BCD limit constants HOUR_MAX=6'h23 and MIN_MAX=7'h59.
- One sub-module, bcd_inc: a parameterised BCD increment with a wrap limit. It is instantiated for AL_HOUR and for AL_MIN.

## Test plan
- Reset, then ALSET, then 3×ADJUST, SELECT, 2×ADJUST, ALSET. Required: AL_HOUR=6'h10, AL_MIN=7'h02, ALDISP high only between the two ALSETs, HOURON blinking only in SETH.
- Wrap: AL_HOUR from 6'h23 plus ADJUST gives 6'h00. AL_MIN from 7'h59 plus ADJUST gives 7'h00. The 09→10 increments are correct for both.
- ARM=1, alarm 07:00; drive time 06:59:59 → 07:00:00 on EN1HZ. Required: RING two cycles later; BUZZ toggles with SIG2HZ; back to IDLE after 60 EN1HZ.
- In RING, SELECT goes to SNOOZE with BUZZ=0 and RINGING=1. After 300 EN1HZ the block returns to RING. STOP then gives IDLE.
- ARM=0 at match time gives no RING. Dropping ARM in SNOOZE gives IDLE next cycle.
- RST asserted in SNOOZE: next cycle IDLE, BUZZ=0, AL_HOUR=6'h07, AL_MIN=7'h00.
